// File: rtl/p_mul_seq_pkg.sv
// Shared definitions for the packed multiplier: pack-width encoding, FSM states
// and per-width lane masks.
package p_pkg;

   localparam int PW_BIT_32 = 0;
   localparam int PW_BIT_16 = 1;
   localparam int PW_BIT_8  = 2;
   localparam int PW_BIT_4  = 3;
   localparam int PW_BIT_2  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0] LANE_MSB_32 = 32'h8000_0000;
   localparam logic [31:0] LANE_MSB_16 = 32'h8000_8000;
   localparam logic [31:0] LANE_MSB_8  = 32'h8080_8080;
   localparam logic [31:0] LANE_MSB_4  = 32'h8888_8888;
   localparam logic [31:0] LANE_MSB_2  = 32'hAAAA_AAAA;

   localparam logic [31:0] LANE_LSB_32 = 32'h0000_0001;
   localparam logic [31:0] LANE_LSB_16 = 32'h0001_0001;
   localparam logic [31:0] LANE_LSB_8  = 32'h0101_0101;
   localparam logic [31:0] LANE_LSB_4  = 32'h1111_1111;
   localparam logic [31:0] LANE_LSB_2  = 32'h5555_5555;

   typedef struct packed {
      logic [4:0]  width_m1;
      logic [31:0] lsb_mask;
      logic [31:0] msb_mask;
   } lane_cfg_t;

   function automatic logic pw_is_onehot(input logic [4:0] pw);
      return (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);
   endfunction

   // Anything that is not exactly one-hot falls back to a single 32-bit lane.
   function automatic lane_cfg_t pw_decode(input logic [4:0] pw);
      lane_cfg_t cfg;
      cfg.width_m1 = 5'd31;
      cfg.lsb_mask = LANE_LSB_32;
      cfg.msb_mask = LANE_MSB_32;
      if (pw_is_onehot(pw)) begin
         if (pw[PW_BIT_16]) begin
            cfg.width_m1 = 5'd15;
            cfg.lsb_mask = LANE_LSB_16;
            cfg.msb_mask = LANE_MSB_16;
         end else if (pw[PW_BIT_8]) begin
            cfg.width_m1 = 5'd7;
            cfg.lsb_mask = LANE_LSB_8;
            cfg.msb_mask = LANE_MSB_8;
         end else if (pw[PW_BIT_4]) begin
            cfg.width_m1 = 5'd3;
            cfg.lsb_mask = LANE_LSB_4;
            cfg.msb_mask = LANE_MSB_4;
         end else if (pw[PW_BIT_2]) begin
            cfg.width_m1 = 5'd1;
            cfg.lsb_mask = LANE_LSB_2;
            cfg.msb_mask = LANE_MSB_2;
         end
      end
      return cfg;
   endfunction

endpackage

// File: rtl/p_mul_lane_shift.sv
// Per-lane right shift of {carry, hi, lo} by one bit; nothing crosses a lane edge.
module p_mul_lane_shift
   import p_pkg::*;
(
   input  logic [4:0]  pw,
   input  logic [31:0] carry,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next
);

   lane_cfg_t   cfg;
   logic [31:0] hi_lsb;

   assign cfg    = pw_decode(pw);
   assign hi_lsb = hi & cfg.lsb_mask;

   // At a lane MSB the hi half takes the lane carry and the lo half takes the
   // bit leaving the bottom of the same lane's hi half.
   always_comb begin
      hi_next = '0;
      lo_next = '0;
      for (int i = 0; i < 31; i++) begin
         hi_next[i] = cfg.msb_mask[i] ? carry[i] : hi[i+1];
         lo_next[i] = cfg.msb_mask[i] ? hi_lsb[5'(i) & ~cfg.width_m1] : lo[i+1];
      end
      hi_next[31] = carry[31];
      lo_next[31] = hi_lsb[5'd31 & ~cfg.width_m1];
   end

endmodule

// File: rtl/p_mul_seq.sv
// Sequential shift-add packed multiplier driving an external packed adder.
// Define XC_PMUL_CLMUL_EN to honour the carry-less (clmul) request.
module p_mul_seq
   import p_pkg::*;
(
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        valid,
   output logic        ready,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [4:0]  pw,
   input  logic        high,
   input  logic        clmul,
   input  logic        flush,
   output logic        out_valid,
   output logic [31:0] out_result,
   output logic [31:0] add_lhs,
   output logic [31:0] add_rhs,
   output logic [4:0]  add_pw,
   output logic        add_cin,
   output logic        add_sub,
   output logic        add_c_en,
   input  logic [31:0] add_result,
   input  logic [32:0] add_c_out
);

   state_t      state;
   logic [31:0] rs1_r;
   logic [31:0] acc_lo;
   logic [31:0] acc_hi;
   logic [4:0]  pw_r;
   logic [4:0]  cnt;
   logic        high_r;
   lane_cfg_t   cfg;
   logic [31:0] lane_en;
   logic [31:0] rhs;
   logic [31:0] c_vec;
   logic [31:0] hi_next;
   logic [31:0] lo_next;
   logic        unused_sink;

   assign cfg = pw_decode(pw_r);

`ifdef XC_PMUL_CLMUL_EN
   logic clmul_r;
   assign c_vec       = clmul_r ? 32'd0 : add_c_out[31:0];
   assign add_c_en    = ~clmul_r;
   assign unused_sink = add_c_out[32];
`else
   assign c_vec       = add_c_out[31:0];
   assign add_c_en    = 1'b1;
   assign unused_sink = add_c_out[32] ^ clmul;
`endif

   // Each lane adds its rs1 lane only when the current multiplier bit (the
   // lane LSB of acc_lo) is set.
   always_comb begin
      rhs     = '0;
      lane_en = acc_lo & cfg.lsb_mask;
      for (int i = 0; i < 32; i++) begin
         rhs[i] = rs1_r[i] & lane_en[5'(i) & ~cfg.width_m1];
      end
   end

   assign add_lhs = acc_hi;
   assign add_rhs = rhs;
   assign add_pw  = pw_r;
   assign add_cin = 1'b0;
   assign add_sub = 1'b0;

   p_mul_lane_shift u_shift (
      .pw      (pw_r),
      .carry   (c_vec),
      .hi      (add_result),
      .lo      (acc_lo),
      .hi_next (hi_next),
      .lo_next (lo_next)
   );

   // Flush beats everything except reset and leaves the last result visible.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state      <= S_IDLE;
         ready      <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         rs1_r      <= '0;
         acc_lo     <= '0;
         acc_hi     <= '0;
         pw_r       <= '0;
         cnt        <= '0;
         high_r     <= 1'b0;
`ifdef XC_PMUL_CLMUL_EN
         clmul_r    <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
            ready <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (valid) begin
                     rs1_r   <= rs1;
                     pw_r    <= pw;
                     high_r  <= high;
`ifdef XC_PMUL_CLMUL_EN
                     clmul_r <= clmul;
`endif
                     acc_lo  <= rs2;
                     acc_hi  <= '0;
                     cnt     <= '0;
                     state   <= S_RUN;
                     ready   <= 1'b0;
                  end
               end
               S_RUN: begin
                  acc_hi <= hi_next;
                  acc_lo <= lo_next;
                  cnt    <= cnt + 5'd1;
                  if (cnt == cfg.width_m1) begin
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  out_result <= high_r ? acc_hi : acc_lo;
                  out_valid  <= 1'b1;
                  state      <= S_IDLE;
                  ready      <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/p_mul_seq.md
Name: p_mul_seq

Overview:
- Sequential packed multiplier; drives the packed adder interface as its initiator.
- Uses shift-add iteration: one packed add per cycle on all lanes in parallel.
- Produces the low or high half of each lane product; carry-less variant is optional.
- Sits in the xcrypto packed-arithmetic datapath beside the combinational packed adder, sharing its pack-width encoding.

Parameters:
- none (fixed 32-bit datapath; lane widths fixed by one-hot pack-width encoding)

Ports:
- g_clk  input  1  clock
- g_resetn  input  1  synchronous active-low reset
- valid  input  1  request strobe
- ready  output  1  block idle, request accepted when valid && ready
- rs1  input  32  multiplicand lanes
- rs2  input  32  multiplier lanes
- pw  input  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2
- high  input  1  1 = return upper half of each 2W-bit lane product, 0 = lower half
- clmul  input  1  carry-less multiply request
- flush  input  1  abort in-flight operation
- out_valid  output  1  one-cycle result strobe
- out_result  output  32  packed result, held until next out_valid
- add_lhs  output  32  adder left operand
- add_rhs  output  32  adder right operand
- add_pw  output  5  adder pack width (registered pw)
- add_cin  output  1  constant 0
- add_sub  output  1  constant 0
- add_c_en  output  1  adder carry enable (0 for carry-less)
- add_result  input  32  adder sum, combinational from add_* outputs
- add_c_out  input  33  adder carry outputs; add_c_out[j] = carry out of bit j

Behaviour:
- Reset (g_resetn=0 at rising edge), all state cleared:
  - ready=1, out_valid=0, out_result=0
  - accumulators=0, counter=0, state=IDLE
- Invalid pw (not one-hot, including 0) is treated as pw=32. W = lane width in {2,4,8,16,32}.
- States:
  - IDLE: ready=1. On valid, register rs1, pw, high, clmul; set acc_lo=rs2, acc_hi=0, cnt=0; go to RUN.
  - RUN: ready=1 only in IDLE, so valid is ignored here. Each cycle:
    - add_lhs=acc_hi; add_rhs = rs1_r masked per lane by each lane's acc_lo LSB (lane LSB=1 passes that rs1 lane, else 0).
    - Per lane, take c = add_c_out[lane MSB index], forced 0 when clmul_r.
    - Per lane, shift {c, add_result lane, acc_lo lane} right by one.
    - cnt++. When cnt reaches W-1 this cycle, go to DONE.
  - DONE: out_result = high_r ? acc_hi : acc_lo; out_valid=1 for exactly this cycle; then IDLE.
- Latency: out_valid is asserted exactly W+1 cycles after the acceptance edge. Back-to-back requests: next accept is possible in the IDLE cycle after DONE.
- Lane isolation: no bit crosses a lane boundary in the shift. Adder carry masking isolates lanes in the add.
- add_c_en = !clmul_r. add_cin and add_sub are tied 0. When clmul_r, the adder performs lane XOR.
- Signedness: unsigned operands only; signed fix-up is done by the issuing stage.
- flush: at the edge, any state goes to IDLE with no out_valid; out_result is retained. If flush and valid arrive together in IDLE, flush wins and nothing is accepted.
- Reset mid-operation: same as flush, plus out_result=0.
- Counter is 5 bits; it never wraps because the maximum count is 31.

Optional Feature:
- XC_PMUL_CLMUL_EN defined: clmul input honoured as above.
- Undefined: clmul is ignored (registered as 0); add_c_en is tied 1; carry-less logic is removed.

Decomposition:
- Shared package (p_pkg), containing:
  - one-hot pw bit positions
  - state encoding (IDLE, RUN, DONE)
  - lane-MSB index constants per width
  - a function returning W and a per-lane LSB/MSB mask from pw
- Sub-module p_mul_lane_shift: combinational per-lane right shift of {carry, hi, lo} given pw. Instantiated once.
- The adder itself is external, connected through the add_* ports.

Test Plan:
- pw=00001, rs1=0x00000003, rs2=0x00000005, high=0 -> out_valid 33 cycles after accept, out_result=0x0000000F.
- pw=00001, rs1=rs2=0xFFFFFFFF -> high=1 gives 0xFFFFFFFE; high=0 gives 0x00000001.
- pw=00100, rs1=0x02FF1003, rs2=0x03FF1005 -> latency 9; high=0 gives 0x0601000F; high=1 gives 0x00FE0100.
- pw=00001, rs1=rs2=0x00000003, clmul=1 -> 0x00000005 with XC_PMUL_CLMUL_EN; 0x00000009 without it. add_c_en observed 0 / 1 respectively during RUN.
- Start pw=32 op; drive g_resetn=0 on cycle 10 -> next cycle ready=1, out_result=0; no out_valid in the following 40 cycles.
- Start pw=32 op:
  - valid held high during RUN -> ready=0, no second accept.
  - flush on cycle 5 -> IDLE next cycle, no out_valid, previous out_result unchanged.
  - new pw=2 op then completes in 3 cycles.
